pll_phase_stepper: RTL and testbench

- Sequencer for the ECP5 EHXPLLL dynamic phase-shift port: PHASESEL, PHASEDIR, PHASESTEP.
- Takes a request for a channel, a direction and a step count, then issues that many correctly timed PHASESTEP pulses.
- Keeps a per-channel phase-position counter that wraps modulo one output period.
- Sits next to the PLL wrapper in the clocks directory. Used for run-time SDRAM/video clock phase tuning in place of fixed CPHASE/FPHASE parameters.

---
 rtl/pll_phase_stepper.sv | 146 ++++++++++++++
 tb/tb_pll_phase_stepper.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_stepper.sv
// Sequencer for the ECP5 EHXPLLL dynamic phase-shift port. It issues paced PHASESTEP pulses
// for one channel and tracks a per-channel phase position modulo one output period.
module pll_phase_stepper #(
  parameter int unsigned STEPW = 8,
  parameter int unsigned POSW  = 6,
  parameter int unsigned WRAP  = 48,
  parameter int unsigned SETUP = 2,
  parameter int unsigned PULSE = 4,
  parameter int unsigned HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_chan,
  input  logic              req_dir,
  input  logic [STEPW-1:0]  req_steps,
  output logic              done,
  output logic              err,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic [4*POSW-1:0] pos
);

  localparam int unsigned MAXT = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                                 : ((PULSE > HOLD) ? PULSE : HOLD);
  localparam int unsigned CNTW = (MAXT > 1) ? $clog2(MAXT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE} state_t;

  state_t           state, state_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic [STEPW-1:0] remain;
  logic [1:0]       chan;
  logic [POSW-1:0]  posr [4];
  logic             accept, step_done, abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    step_done = 1'b0;
    abort     = 1'b0;
    req_ready = (state == S_IDLE) && locked && !reset;
    done      = (state == S_DONE);
    phasestep = (state == S_PULSE);
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (req_steps == '0) begin
            state_n = S_DONE;
          end else begin
            state_n = S_SETUP;
            cnt_n   = CNTW'(SETUP - 1);
          end
        end
      end
      S_SETUP: begin
        if (!locked) begin
          abort = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_PULSE;
          cnt_n   = CNTW'(PULSE - 1);
        end else begin
          cnt_n = cnt - CNTW'(1);
        end
      end
      S_PULSE: begin
        if (!locked) begin
          abort = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_HOLD;
          cnt_n   = CNTW'(HOLD - 1);
        end else begin
          cnt_n = cnt - CNTW'(1);
        end
      end
      S_HOLD: begin
        // Lock loss on the final HOLD cycle still aborts, so that step is not counted.
        if (!locked) begin
          abort = 1'b1;
        end else if (cnt == '0) begin
          step_done = 1'b1;
          if (remain == STEPW'(1)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_SETUP;
            cnt_n   = CNTW'(SETUP - 1);
          end
        end else begin
          cnt_n = cnt - CNTW'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chan     <= '0;
      remain   <= '0;
      phasesel <= 2'b11;
      phasedir <= 1'b0;
      err      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) posr[i] <= '0;
    end else begin
      if (accept) begin
        chan     <= req_chan;
        // EHXPLLL encoding is the channel index minus one, modulo 4 (CLKOP -> 11).
        phasesel <= req_chan - 2'd1;
        phasedir <= req_dir;
        remain   <= req_steps;
        err      <= 1'b0;
      end
      if (abort) err <= 1'b1;
      if (step_done) begin
        remain <= remain - STEPW'(1);
        if (!phasedir)
          posr[chan] <= (posr[chan] == POSW'(WRAP - 1)) ? '0 : posr[chan] + POSW'(1);
        else
          posr[chan] <= (posr[chan] == '0) ? POSW'(WRAP - 1) : posr[chan] - POSW'(1);
      end
    end
  end

  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < 4; i++) pos[i*POSW +: POSW] = posr[i];
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Bench for pll_phase_stepper: directed scenarios plus randomized traffic against a
// cycle-count-based reference model of the request timeline and positions.
module tb_pll_phase_stepper;

  localparam int STEPW = 8;
  localparam int POSW  = 6;
  localparam int WRAP  = 48;
  localparam int SETUP = 2;
  localparam int PULSE = 4;
  localparam int HOLD  = 4;
  localparam int P     = SETUP + PULSE + HOLD;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              locked = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_chan = '0;
  logic              req_dir = 1'b0;
  logic [STEPW-1:0]  req_steps = '0;
  logic              done, err, phasedir, phasestep;
  logic [1:0]        phasesel;
  logic [4*POSW-1:0] pos;

  pll_phase_stepper #(.STEPW(STEPW), .POSW(POSW), .WRAP(WRAP),
                      .SETUP(SETUP), .PULSE(PULSE), .HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .locked(locked),
    .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
    .req_dir(req_dir), .req_steps(req_steps), .done(done), .err(err),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .pos(pos)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 busy (m_k = cycles since accept), 2 done cycle.
  int m_mode = 0, m_k = 0, m_n = 0, m_chan = 0, m_dir = 0, m_sel = 3, m_err = 0;
  int m_pos[4] = '{0, 0, 0, 0};
  int acc_cnt = 0;
  int sel_tab[4] = '{3, 0, 1, 2};
  bit started = 1'b0;

  initial forever begin
    @(posedge clk);
    started = 1'b1;
    if (reset) begin
      m_mode = 0; m_err = 0; m_sel = 3; m_dir = 0;
      for (int i = 0; i < 4; i++) m_pos[i] = 0;
    end else begin
      case (m_mode)
        0: if (req_valid && locked) begin
          acc_cnt++;
          m_chan = int'(req_chan); m_dir = int'(req_dir); m_n = int'(req_steps);
          m_sel = sel_tab[m_chan]; m_err = 0; m_k = 1;
          m_mode = (m_n == 0) ? 2 : 1;
        end
        1: begin
          if (!locked) begin
            m_err = 1; m_mode = 2;
          end else if (m_k % P == 0) begin
            m_pos[m_chan] = m_dir ? (m_pos[m_chan] + WRAP - 1) % WRAP : (m_pos[m_chan] + 1) % WRAP;
            if (m_k / P == m_n) m_mode = 2;
            else m_k++;
          end else begin
            m_k++;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  initial forever begin
    logic [4*POSW-1:0] ep;
    int ph;
    @(negedge clk);
    if (started) begin
      ph = (m_k - 1) % P;
      ep = '0;
      for (int c = 0; c < 4; c++) ep[c*POSW +: POSW] = POSW'(m_pos[c]);
      chk("req_ready", 32'(req_ready), 32'(m_mode == 0 && locked && !reset));
      chk("done", 32'(done), 32'(m_mode == 2));
      chk("err", 32'(err), 32'(m_err));
      chk("phasestep", 32'(phasestep), 32'(m_mode == 1 && ph >= SETUP && ph < SETUP + PULSE));
      chk("phasesel", 32'(phasesel), 32'(m_sel));
      chk("phasedir", 32'(phasedir), 32'(m_dir));
      chk("pos", 32'(pos), 32'(ep));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_req(input int ch, input int dir, input int steps);
    int a0, n;
    a0 = acc_cnt;
    req_valid = 1'b1; req_chan = 2'(ch); req_dir = 1'(dir); req_steps = STEPW'(steps);
    n = 0;
    do begin tick(); n++; end while (acc_cnt == a0 && n < 200);
    chk("accept_seen", 32'(acc_cnt != a0), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int hi);
    int n;
    n = 0; hi = 0;
    while (!done && n < 3000) begin
      tick(); n++;
      if (phasestep) hi++;
    end
    chk("done_seen", 32'(done), 32'd1);
    lat = n + 1;
  endtask

  task automatic do_req(input int ch, input int dir, input int steps, output int lat, output int hi);
    start_req(ch, dir, steps);
    wait_done(lat, hi);
  endtask

  initial begin
    int lat, hi, a0, last_acc;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_sel", 32'(phasesel), 32'd3);
    chk("rst_step", 32'(phasestep), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick();

    do_req(1, 0, 3, lat, hi);
    chk("t1_latency", 32'(lat), 32'd31);
    chk("t1_pulse_cycles", 32'(hi), 32'd12);
    chk("t1_sel", 32'(phasesel), 32'd0);
    chk("t1_pos", 32'(pos), 32'h0000C0);
    chk("t1_model_pos1", 32'(m_pos[1]), 32'd3);

    do_req(2, 1, 1, lat, hi);
    chk("t2_latency", 32'(lat), 32'd11);
    chk("t2_pulse_cycles", 32'(hi), 32'd4);
    chk("t2_sel", 32'(phasesel), 32'd1);
    chk("t2_dir", 32'(phasedir), 32'd1);
    chk("t2_pos2", 32'(pos[17:12]), 32'd47);
    chk("t2_model_pos2", 32'(m_pos[2]), 32'd47);

    do_req(0, 1, 2, lat, hi);
    chk("t3_pos0_pre", 32'(pos[5:0]), 32'd46);
    do_req(0, 0, 5, lat, hi);
    chk("t3_latency", 32'(lat), 32'd51);
    chk("t3_sel", 32'(phasesel), 32'd3);
    chk("t3_pos0", 32'(pos[5:0]), 32'd3);
    chk("t3_model_pos0", 32'(m_pos[0]), 32'd3);

    do_req(3, 0, 0, lat, hi);
    chk("t4_latency", 32'(lat), 32'd1);
    chk("t4_pulse_cycles", 32'(hi), 32'd0);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_pos", 32'(pos), 32'h02F0C3);

    // Abort during the second pulse of a 4-step request on channel 1 (pos 3).
    start_req(1, 0, 4);
    repeat (13) tick();
    chk("t5_in_pulse", 32'(phasestep), 32'd1);
    locked = 1'b0;
    tick();
    chk("t5_step_low", 32'(phasestep), 32'd0);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    repeat (3) tick();
    chk("t5_ready_unlocked", 32'(req_ready), 32'd0);
    chk("t5_pos1", 32'(pos[11:6]), 32'd4);
    locked = 1'b1;
    tick();
    do_req(3, 0, 0, lat, hi);
    chk("t5_err_cleared", 32'(err), 32'd0);

    // Request held while unlocked, then reset in mid-pulse.
    locked = 1'b0;
    a0 = acc_cnt;
    req_valid = 1'b1; req_chan = 2'd2; req_dir = 1'b0; req_steps = 8'd2;
    repeat (5) tick();
    chk("t6_not_accepted", 32'(phasesel), 32'd2);
    chk("t6_model_no_acc", 32'(acc_cnt - a0), 32'd0);
    locked = 1'b1;
    tick();
    chk("t6_accepted", 32'(phasesel), 32'd1);
    req_valid = 1'b0;
    repeat (3) tick();
    chk("t6_in_pulse", 32'(phasestep), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_step", 32'(phasestep), 32'd0);
    chk("t6_rst_pos", 32'(pos), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    last_acc = acc_cnt;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      locked = ($urandom_range(0, 199) != 0);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 2999) == 0) reset = 1'b1;
      if (req_valid && acc_cnt != last_acc) req_valid = 1'b0;
      if (!req_valid) begin
        req_chan = 2'($urandom_range(0, 3));
        req_dir  = 1'($urandom_range(0, 1));
        req_steps = ($urandom_range(0, 19) == 0) ? STEPW'($urandom_range(0, 255))
                                                 : STEPW'($urandom_range(0, 6));
        if ($urandom_range(0, 3) == 0) begin
          req_valid = 1'b1;
          last_acc = acc_cnt;
        end
      end
      tick();
    end
    req_valid = 1'b0;
    reset = 1'b0;
    locked = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
